sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter and timing sequencer for the board's external asynchronous 16-bit SRAM (19-bit address, active-low OE/WE/CS). Two internal requesters issue single-word reads and writes over a req/ack handshake. The block grants the SRAM round-robin and drives the chip strobes with registered, glitch-free timing. It sits in the chip top level between user logic and the SRAM pins; the top level owns the DAT tristate buffer.

## Interface
- WAIT_CYCLES, 2, cycles OE_n/WE_n is held low per access; legal 1..15 (2 = 20 ns at 100 MHz)
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until matching ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  19  word address
- wdata0 / wdata1  in  16  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  16  read data, valid in the ack cycle and held until that port's next read completes
- ram_adr  out  19  SRAM address pins
- ram_dat_out  out  16  data to SRAM
- ram_dat_oe  out  1  1 = top level drives DAT from ram_dat_out
- ram_dat_in  in  16  data from SRAM pins
- ram_oe_n, ram_we_n, ram_cs_n  out  1  SRAM strobes, active low
- busy  out  1  high in any state other than IDLE

## Operation
- All outputs are registered. FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: cs_n/oe_n/we_n = 1, dat_oe = 0. Samples req0/req1. If any is high:
  - Grant the port. If both are high, grant the port not served last (last_grant toggles).
  - Latch that port's we/addr/wdata.
  - Go to SETUP.
- SETUP (1 cycle): ram_adr = latched address, cs_n = 0. For a write: dat_oe = 1 and ram_dat_out = wdata. oe_n and we_n stay 1. Load the wait counter with WAIT_CYCLES. Go to STROBE.
- STROBE (WAIT_CYCLES cycles): oe_n = 0 for a read, we_n = 0 for a write. Never both. At the clock edge ending the last STROBE cycle:
  - a read captures ram_dat_in into the granted port's rdata;
  - the state goes to HOLD.
- HOLD (1 cycle): oe_n = we_n = 1. cs_n stays 0. adr and dat_out stay unchanged, giving write data hold time. dat_oe stays 1 for a write. The granted port's ack = 1. Go to IDLE.
- The IDLE cycle after HOLD has cs_n = 1 and dat_oe = 0. This guarantees one bus turnaround cycle between accesses.
- Requester inputs are only sampled in IDLE:
  - changes to them after the grant are ignored;
  - dropping req mid-access does not abort the access, and ack is still issued.
- A requester holding req high in the cycle after its ack starts a new access.
- Ports that are not granted keep waiting and get no ack.

## Timing
- Access length is WAIT_CYCLES + 3 cycles including the turnaround IDLE: 5 cycles at default.
- Latency: req sampled high in IDLE at cycle t gives ack at cycle t + WAIT_CYCLES + 2.
- Back-to-back requests from either port: the next grant is decided in the IDLE cycle after HOLD.
- Reset values: ram_cs_n = ram_oe_n = ram_we_n = 1, ram_dat_oe = 0, ram_adr = 0, ram_dat_out = 0, ack0 = ack1 = 0, rdata0 = rdata1 = 0, busy = 0, state IDLE, last_grant = 1 (port 0 wins the first contention).
- Reset asserted mid-access: strobes go inactive and dat_oe = 0 immediately (asynchronous). The access is dropped and no ack is issued.
- rst_n deassertion is synchronised externally; the block treats it as clean.

## Test plan
- Single write: after reset, port 0 writes 0xA5A5 to 0x12345 with WAIT_CYCLES = 2 -> cs_n low for 4 cycles, we_n low for exactly 2, dat_oe high cycles 1–4 after grant, ack0 at t+4, oe_n never low.
- Single read: port 1 reads 0x7FFFF while the SRAM model returns 0xBEEF -> oe_n low for 2 cycles, we_n stays 1, dat_oe stays 0, rdata1 = 0xBEEF in the ack1 cycle and held afterwards.
- Contention: req0 and req1 are raised in the same cycle and held -> grant order 0, 1, 0, 1; each ack is 5 cycles apart; no ack appears on the wrong port.
- Turnaround: port 0 read directly followed by a port 1 write -> at least one cycle with cs_n = 1 and dat_oe = 0 between HOLD and the next SETUP; dat_oe is never 1 while oe_n = 0.
- Input change: addr0 changed and req0 dropped during STROBE -> ram_adr unchanged, ack0 still pulses once.
- Reset mid-access: rst_n pulled low during STROBE of a write -> we_n, cs_n = 1 and dat_oe = 0 with no clock edge; no ack; a new request after release completes normally.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Round-robin two-port arbiter and registered strobe sequencer for
//            an external asynchronous 16-bit SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [18:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [18:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic [18:0] ram_adr,
  output logic [15:0] ram_dat_out,
  output logic        ram_dat_oe,
  input  logic [15:0] ram_dat_in,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_cs_n,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [18:0] adr_q, adr_d;
  logic [15:0] dat_out_q, dat_out_d;
  logic        dat_oe_q, dat_oe_d;
  logic        cs_n_q, cs_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        busy_q, busy_d;
  logic        pick;

  // Every output is the registered image of the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_out_d    = dat_out_q;
    dat_oe_d     = 1'b0;
    cs_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    pick         = (req0 && req1) ? ~last_grant_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d        = pick;
          last_grant_d = pick;
          we_d         = pick ? we1 : we0;
          adr_d        = pick ? addr1 : addr0;
          if (pick ? we1 : we0) begin
            dat_out_d = pick ? wdata1 : wdata0;
          end
          cs_n_d   = 1'b0;
          dat_oe_d = pick ? we1 : we0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cs_n_d   = 1'b0;
        dat_oe_d = we_q;
        oe_n_d   = we_q;
        we_n_d   = ~we_q;
        cnt_d    = c_wait_init;
        state_d  = STROBE;
      end
      STROBE: begin
        cs_n_d   = 1'b0;
        dat_oe_d = we_q;
        if (cnt_q == 4'd1) begin
          state_d = HOLD;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          if (!we_q) begin
            if (gnt_q) rdata1_d = ram_dat_in;
            else       rdata0_d = ram_dat_in;
          end
        end else begin
          oe_n_d = we_q;
          we_n_d = ~we_q;
          cnt_d  = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Asynchronous reset forces the strobes inactive without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      adr_q        <= 19'd0;
      dat_out_q    <= 16'd0;
      dat_oe_q     <= 1'b0;
      cs_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 16'd0;
      rdata1_q     <= 16'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_out_q    <= dat_out_d;
      dat_oe_q     <= dat_oe_d;
      cs_n_q       <= cs_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ram_adr     = adr_q;
  assign ram_dat_out = dat_out_q;
  assign ram_dat_oe  = dat_oe_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign ram_cs_n    = cs_n_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed, table-driven self-checking bench for sram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [18:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [18:0] ram_adr;
  logic [15:0] ram_dat_out, ram_dat_in;
  logic        ram_dat_oe, ram_oe_n, ram_we_n, ram_cs_n, busy;

  int n_cmp = 0;
  int n_err = 0;
  int conflicts = 0;

  logic [15:0] mem [logic [18:0]];

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_adr(ram_adr), .ram_dat_out(ram_dat_out), .ram_dat_oe(ram_dat_oe),
    .ram_dat_in(ram_dat_in), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_cs_n(ram_cs_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: stores on WE, presents the addressed word on the data-in bus.
  always @(negedge clk) begin
    if (!ram_cs_n && !ram_we_n) mem[ram_adr] = ram_dat_out;
    if (mem.exists(ram_adr)) ram_dat_in <= mem[ram_adr];
    else                     ram_dat_in <= 16'h5A5A;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_dat_oe && !ram_oe_n) conflicts++;
      if (!ram_oe_n && !ram_we_n) conflicts++;
      if (ram_cs_n && (!ram_oe_n || !ram_we_n)) conflicts++;
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int ack_k = 0, cs_cnt = 0, oe_cnt = 0, we_cnt = 0, doe_cnt = 0;
    int adr_err = 0, dout_err = 0, wrong = 0;
    @(posedge clk); #1;
    if (v.port == 1'b0) begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    else                begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    @(negedge clk);
    for (int k = 1; k <= 12 && ack_k == 0; k++) begin
      @(negedge clk);
      if (!ram_cs_n) begin
        cs_cnt++;
        if (ram_adr !== v.addr) adr_err++;
        if (v.we && ram_dat_out !== v.wdata) dout_err++;
      end
      if (!ram_oe_n)  oe_cnt++;
      if (!ram_we_n)  we_cnt++;
      if (ram_dat_oe) doe_cnt++;
      if (v.port ? ack0 : ack1) wrong++;
      if (v.port ? ack1 : ack0) begin
        ack_k = k;
        if (!v.we) chk({tag, "_rdata"}, 32'(v.port ? rdata1 : rdata0), 32'(v.exp_rdata));
      end
    end
    @(posedge clk); #1;
    if (v.port == 1'b0) req0 = 1'b0; else req1 = 1'b0;
    chk({tag, "_ack_latency"}, 32'(ack_k), 32'(W + 2));
    chk({tag, "_cs_cycles"}, 32'(cs_cnt), 32'(W + 2));
    chk({tag, "_we_cycles"}, 32'(we_cnt), v.we ? 32'(W) : 32'd0);
    chk({tag, "_oe_cycles"}, 32'(oe_cnt), v.we ? 32'd0 : 32'(W));
    chk({tag, "_datoe_cycles"}, 32'(doe_cnt), v.we ? 32'(W + 2) : 32'd0);
    chk({tag, "_adr_errors"}, 32'(adr_err), 32'd0);
    chk({tag, "_dout_errors"}, 32'(dout_err), 32'd0);
    chk({tag, "_wrong_port_ack"}, 32'(wrong), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_cs_datoe_busy"}, {29'd0, ram_cs_n, ram_dat_oe, busy}, 32'h4);
    if (!v.we) chk({tag, "_rdata_held"}, 32'(v.port ? rdata1 : rdata0), 32'(v.exp_rdata));
  endtask

  initial begin
    int nack, gap, acks, adr_bad, waited;
    int ack_port[4];
    int ack_cyc[4];
    vec_t post;

    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem[19'h7FFFF] = 16'hBEEF;
    mem[19'h00010] = 16'h1111;
    mem[19'h00020] = 16'h2222;

    vecs[0] = '{1'b0, 1'b1, 19'h12345, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 19'h7FFFF, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 19'h00000, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 19'h12345, 16'h0000, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b0, 19'h00000, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 19'h12345, 16'h0000, 16'hA5A5};

    repeat (2) @(negedge clk);
    chk("reset_strobes", {29'd0, ram_cs_n, ram_oe_n, ram_we_n}, 32'h7);
    chk("reset_datoe_busy_acks", {28'd0, ram_dat_oe, busy, ack0, ack1}, 32'h0);
    chk("reset_adr", 32'(ram_adr), 32'h0);
    chk("reset_dat_out", 32'(ram_dat_out), 32'h0);
    chk("reset_rdata", {rdata0, rdata1}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 2) chk("rdata1_held_across_write", 32'(rdata1), 32'hBEEF);
    end

    // Contention: last grant was port 1, so port 0 wins first.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 19'h00010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 19'h00020;
    nack = 0;
    for (int c = 1; c <= 40 && nack < 4; c++) begin
      @(negedge clk);
      if (ack0 && ack1) chk("contention_dual_ack", 32'd1, 32'd0);
      if (ack0 || ack1) begin
        ack_port[nack] = ack1 ? 1 : 0;
        ack_cyc[nack]  = c;
        nack++;
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    chk("contention_ack_count", 32'(nack), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contention_order%0d", i), 32'(ack_port[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("contention_spacing%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(W + 3));
    end
    chk("contention_rdata", {rdata0, rdata1}, 32'h1111_2222);
    @(negedge clk);
    @(negedge clk);
    chk("contention_no_extra_access", {30'd0, ram_cs_n, busy}, 32'h2);

    // Turnaround: port 0 read then port 1 write requested in the IDLE after HOLD.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 19'h12345;
    waited = 0;
    while (!ack0 && waited < 12) begin @(negedge clk); waited++; end
    chk("turn_read_ack_seen", 32'(ack0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 19'h00400; wdata1 = 16'hC3C3;
    gap = 0; acks = 0;
    for (int k = 0; k < 12 && acks == 0; k++) begin
      @(negedge clk);
      if (ram_cs_n && !ram_dat_oe && gap == k) gap++;
      if (ack1) acks++;
    end
    @(posedge clk); #1;
    req1 = 1'b0;
    chk("turn_gap_cycles", 32'(gap), 32'd1);
    chk("turn_write_ack", 32'(acks), 32'd1);
    chk("turn_read_rdata", 32'(rdata0), 32'hA5A5);

    // Input change and req drop during STROBE must not disturb the access.
    @(negedge clk);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 19'h00010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("chg_in_strobe_oe", 32'(ram_oe_n), 32'd0);
    req0 = 1'b0; addr0 = 19'h3FFFF; we0 = 1'b1;
    acks = 0; adr_bad = 0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (!ram_cs_n && ram_adr !== 19'h00010) adr_bad++;
      if (ack0) acks++;
    end
    chk("chg_adr_stable", 32'(adr_bad), 32'd0);
    chk("chg_ack_once", 32'(acks), 32'd1);
    chk("chg_rdata", 32'(rdata0), 32'h1111);

    // Asynchronous reset in the middle of a write strobe.
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 19'h00777; wdata1 = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_we_low", 32'(ram_we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {29'd0, ram_cs_n, ram_oe_n, ram_we_n}, 32'h7);
    chk("rst_mid_datoe_busy_ack", {29'd0, ram_dat_oe, busy, ack1}, 32'h0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_rdata_cleared", {rdata0, rdata1}, 32'h0);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack0 || ack1 || !ram_cs_n) acks++;
    end
    chk("rst_mid_no_ack", 32'(acks), 32'd0);
    post = '{1'b0, 1'b1, 19'h00777, 16'h9999, 16'h0000};
    run_vec(post, "post_rst_wr");
    post = '{1'b1, 1'b0, 19'h00777, 16'h0000, 16'h9999};
    run_vec(post, "post_rst_rd");

    chk("bus_conflicts", 32'(conflicts), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
